// File: rtl/div_pkg.sv
// Shared types and default widths for the signed fixed-point divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

   // Default operand and result widths
   localparam int DEF_DIVIDEND_W = 32;
   localparam int DEF_DIVISOR_W  = 8;
   localparam int DEF_QUOTIENT_W = 24;

   // Divider control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, keep or restore.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
   parameter int W = 9
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_o,
   output logic         qbit_o
);

   logic [W:0] partial;
   logic [W:0] trial;

   // Partial remainder is always below 2*divisor, so one extra bit holds the trial sign
   always_comb begin
      partial = {rem_i, bit_i};
      trial   = partial - {1'b0, dvs_i};
      qbit_o  = ~trial[W];
      rem_o   = qbit_o ? trial[W-1:0] : partial[W-1:0];
   end

endmodule

// File: rtl/fixed_point_divider_signed_coef.sv
// Signed dividend / signed coefficient divider, restoring, one quotient bit per cycle, saturating; DIV_REMAINDER_EN adds a remainder output.
// Latency: DIVIDEND_W+1 cycles from accept edge to out_valid (2 for a zero divisor).
// Backpressure: single in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fixed_point_divider_signed_coef
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W,
   parameter int QUOTIENT_W = DEF_QUOTIENT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOTIENT_W-1:0] quotient,
   output logic                  ov,
   output logic                  dz
`ifdef DIV_REMAINDER_EN
   ,
   output logic [DIVISOR_W-1:0]  remainder
`endif
);

   localparam int RW = DIVISOR_W + 1;
   localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [CW-1:0]         CNT_LAST  = CW'(DIVIDEND_W - 1);
   localparam logic [DIVIDEND_W-1:0] Q_POS_MAG = DIVIDEND_W'((64'd1 << (QUOTIENT_W - 1)) - 64'd1);
   localparam logic [DIVIDEND_W-1:0] Q_NEG_MAG = DIVIDEND_W'(64'd1 << (QUOTIENT_W - 1));
   localparam logic [QUOTIENT_W-1:0] Q_MAX     = {1'b0, {(QUOTIENT_W-1){1'b1}}};
   localparam logic [QUOTIENT_W-1:0] Q_MIN     = {1'b1, {(QUOTIENT_W-1){1'b0}}};

   div_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend magnitude shifting out, quotient bits shifting in
   logic [RW-1:0]         dvs_q, dvs_d;     // divisor magnitude; -2^(DIVISOR_W-1) needs the extra bit
   logic [RW-1:0]         rem_q, rem_d;
   logic                  neg_q, neg_d;     // result sign
   logic                  sdvd_q, sdvd_d;   // dividend sign
   logic [QUOTIENT_W-1:0] quo_q, quo_d;
   logic                  ov_q, ov_d;
   logic                  dz_q, dz_d;
`ifdef DIV_REMAINDER_EN
   logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
`endif

   logic [DIVIDEND_W-1:0] dvd_mag;
   logic [RW-1:0]         dvs_ext;
   logic [RW-1:0]         dvs_mag;
   logic [RW-1:0]         step_rem;
   logic                  step_qbit;
   logic [DIVIDEND_W-1:0] qmag_fin;

   // Magnitudes: the dividend is held unsigned so |-2^(W-1)| does not wrap
   always_comb begin
      dvd_mag  = dividend[DIVIDEND_W-1] ? -dividend : dividend;
      dvs_ext  = {divisor[DIVISOR_W-1], divisor};
      dvs_mag  = divisor[DIVISOR_W-1] ? -dvs_ext : dvs_ext;
      qmag_fin = {dvd_q[DIVIDEND_W-2:0], step_qbit};
   end

   div_step #(.W(RW)) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[DIVIDEND_W-1]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   // Next-state: capture in IDLE, iterate in BUSY, finalise sign/saturation on the last step, hold in DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      sdvd_d  = sdvd_q;
      quo_d   = quo_q;
      ov_d    = ov_q;
      dz_d    = dz_q;
`ifdef DIV_REMAINDER_EN
      rmd_d   = rmd_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d   = dvd_mag;
               dvs_d   = dvs_mag;
               rem_d   = '0;
               cnt_d   = '0;
               neg_d   = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
               sdvd_d  = dividend[DIVIDEND_W-1];
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (dvs_q == '0) begin
               // Zero divisor: no iterations, saturate toward the dividend's sign
               state_d = DONE;
               dz_d    = 1'b1;
               ov_d    = 1'b1;
               quo_d   = sdvd_q ? Q_MIN : Q_MAX;
`ifdef DIV_REMAINDER_EN
               rmd_d   = '0;
`endif
            end else begin
               dvd_d = {dvd_q[DIVIDEND_W-2:0], step_qbit};
               rem_d = step_rem;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  dz_d    = 1'b0;
                  if (!neg_q) begin
                     ov_d  = (qmag_fin > Q_POS_MAG);
                     quo_d = (qmag_fin > Q_POS_MAG) ? Q_MAX : qmag_fin[QUOTIENT_W-1:0];
                  end else begin
                     ov_d  = (qmag_fin > Q_NEG_MAG);
                     quo_d = (qmag_fin > Q_NEG_MAG) ? Q_MIN : -qmag_fin[QUOTIENT_W-1:0];
                  end
`ifdef DIV_REMAINDER_EN
                  rmd_d = sdvd_q ? -step_rem[DIVISOR_W-1:0] : step_rem[DIVISOR_W-1:0];
`endif
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         neg_q   <= 1'b0;
         sdvd_q  <= 1'b0;
         quo_q   <= '0;
         ov_q    <= 1'b0;
         dz_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         rmd_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         sdvd_q  <= sdvd_d;
         quo_q   <= quo_d;
         ov_q    <= ov_d;
         dz_q    <= dz_d;
`ifdef DIV_REMAINDER_EN
         rmd_q   <= rmd_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quo_q;
   assign ov        = ov_q;
   assign dz        = dz_q;
`ifdef DIV_REMAINDER_EN
   assign remainder = rmd_q;
`endif

endmodule

// File: tb/tb_fixed_point_divider_signed_coef.sv
// Bench for the signed divider: directed table, stall/reset corner sequences, randomized ops vs arithmetic model.
// Latency: checks DIVIDEND_W+1 (normal) and 2 (zero divisor) cycles to out_valid.
// Backpressure: exercises out_ready stalls and in_valid pulses while busy.
module tb_fixed_point_divider_signed_coef;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] quotient;
   logic        ov;
   logic        dz;
`ifdef DIV_REMAINDER_EN
   logic [7:0]  remainder;
`endif

   int checks = 0;
   int errors = 0;

   fixed_point_divider_signed_coef dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .ov        (ov),
      .dz        (dz)
`ifdef DIV_REMAINDER_EN
      ,
      .remainder (remainder)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  b;
      logic [23:0] q;
      logic        o;
      logic        z;
      logic [7:0]  r;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain signed integer division, then clamp to the 24-bit signed range
   function automatic void model(input logic [31:0] a, input logic [7:0] b,
                                 output logic [23:0] q, output logic o,
                                 output logic z, output logic [7:0] r);
      longint sa, sb, qq, rr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         z = 1'b1;
         o = 1'b1;
         q = (sa >= 0) ? 24'h7FFFFF : 24'h800000;
         r = 8'h00;
      end else begin
         z  = 1'b0;
         qq = sa / sb;
         rr = sa % sb;
         r  = rr[7:0];
         if (qq > 64'sd8388607) begin
            q = 24'h7FFFFF;
            o = 1'b1;
         end else if (qq < -64'sd8388608) begin
            q = 24'h800000;
            o = 1'b1;
         end else begin
            q = qq[23:0];
            o = 1'b0;
         end
      end
   endfunction

   // Called #1 after a posedge while in IDLE; returns #1 after the accept edge
   task automatic start_op(input logic [31:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = 8'($urandom);
   endtask

   // lat counts edges from the accept edge (inclusive) to the first out_valid
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("out_valid_seen", 64'(out_valid), 64'd1);
   endtask

   task automatic handshake();
      chk("in_ready_in_done", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_hs", 64'(out_valid), 64'd0);
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [7:0] b, input logic [23:0] eq,
                         input logic eo, input logic ez, input logic [7:0] er, input string tag);
      int lat;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      start_op(a, b);
      wait_valid(lat);
      chk({tag, "_latency"}, 64'(lat), ez ? 64'd2 : 64'd33);
      chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
      chk({tag, "_ov"}, 64'(ov), 64'(eo));
      chk({tag, "_dz"}, 64'(dz), 64'(ez));
`ifdef DIV_REMAINDER_EN
      chk({tag, "_remainder"}, 64'(remainder), 64'(er));
`else
      if (er === 8'hxx) $display("unused remainder");
`endif
      handshake();
   endtask

   initial begin
      int lat;
      int vcount;
      logic [31:0] ra;
      logic [7:0]  rb;
      logic [23:0] mq;
      logic        mo, mz;
      logic [7:0]  mr;

      tbl[0]  = '{32'hFFFFFA00, 8'h0C, 24'hFFFF80, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{32'h00000007, 8'hFE, 24'hFFFFFD, 1'b0, 1'b0, 8'h01};
      tbl[2]  = '{32'h7FFFFFFF, 8'h01, 24'h7FFFFF, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{32'h80000000, 8'hFF, 24'h7FFFFF, 1'b1, 1'b0, 8'h00};
      tbl[4]  = '{32'hFFFFFFFB, 8'h00, 24'h800000, 1'b1, 1'b1, 8'h00};
      tbl[5]  = '{32'h00000005, 8'h00, 24'h7FFFFF, 1'b1, 1'b1, 8'h00};
      tbl[6]  = '{32'h00000000, 8'h00, 24'h7FFFFF, 1'b1, 1'b1, 8'h00};
      tbl[7]  = '{32'hFFFFFFF9, 8'h02, 24'hFFFFFD, 1'b0, 1'b0, 8'hFF};
      tbl[8]  = '{32'h80000000, 8'h80, 24'h7FFFFF, 1'b1, 1'b0, 8'h00};
      tbl[9]  = '{32'hFF800000, 8'h01, 24'h800000, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{32'hFF7FFFFF, 8'h01, 24'h800000, 1'b1, 1'b0, 8'h00};
      tbl[11] = '{32'h007FFFFF, 8'h01, 24'h7FFFFF, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{32'h00800000, 8'h01, 24'h7FFFFF, 1'b1, 1'b0, 8'h00};
      tbl[13] = '{32'h00000064, 8'h07, 24'h00000E, 1'b0, 1'b0, 8'h02};
      tbl[14] = '{32'hFFFFFF9C, 8'hF9, 24'h00000E, 1'b0, 1'b0, 8'hFE};
      tbl[15] = '{32'h80000000, 8'h7F, 24'h800000, 1'b1, 1'b0, 8'hF8};
      tbl[16] = '{32'h00FFFF00, 8'h02, 24'h7FFF80, 1'b0, 1'b0, 8'h00};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_ov", 64'(ov), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed vectors
      for (int i = 0; i < 17; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].o, tbl[i].z, tbl[i].r, $sformatf("tbl%0d", i));
      end

      // Output stall: result held for 10 cycles, in_valid during DONE ignored
      start_op(32'd100, 8'd7);
      wait_valid(lat);
      chk("stall_latency", 64'(lat), 64'd33);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = 32'd5;
         divisor  = 8'd1;
         @(posedge clk);
         #1;
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_quotient", 64'(quotient), 64'h00000E);
         chk("stall_ov", 64'(ov), 64'd0);
         chk("stall_dz", 64'(dz), 64'd0);
      end
      in_valid = 1'b0;
      handshake();
      chk("idle_hold_quotient", 64'(quotient), 64'h00000E);

      // in_valid pulsed during BUSY must not disturb the running division
      start_op(32'd1000, 8'd10);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      chk("busy_hold_quotient", 64'(quotient), 64'h00000E);
      in_valid = 1'b1;
      dividend = 32'hFFFFFFFF;
      divisor  = 8'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("busy_pulse_quotient", 64'(quotient), 64'd100);
      chk("busy_pulse_ov", 64'(ov), 64'd0);
      handshake();

      // Reset mid-BUSY: outputs cleared, abandoned result never appears
      start_op(32'd12345, 8'd3);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rstbusy_out_valid", 64'(out_valid), 64'd0);
      chk("rstbusy_quotient", 64'(quotient), 64'd0);
      chk("rstbusy_ov", 64'(ov), 64'd0);
      chk("rstbusy_dz", 64'(dz), 64'd0);
      chk("rstbusy_in_ready", 64'(in_ready), 64'd1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) vcount++;
      end
      chk("rstbusy_no_result", 64'(vcount), 64'd0);

      // Reset mid-DONE
      start_op(32'hFFFFFFFB, 8'd0);
      wait_valid(lat);
      chk("rstdone_dz_before", 64'(dz), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rstdone_out_valid", 64'(out_valid), 64'd0);
      chk("rstdone_quotient", 64'(quotient), 64'd0);
      chk("rstdone_ov", 64'(ov), 64'd0);
      chk("rstdone_dz", 64'(dz), 64'd0);
      run_op(tbl[0].a, tbl[0].b, tbl[0].q, tbl[0].o, tbl[0].z, tbl[0].r, "post_rst");

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 200; i++) begin
         ra = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) ra = -ra;
         rb = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) rb = 8'h00;
         model(ra, rb, mq, mo, mz, mr);
         run_op(ra, rb, mq, mo, mz, mr, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
